// File: rtl/result_accum.sv
// Burst accumulator for the 9-bit add/subtract result stage: sums BURST samples
// (or fewer on flush) into a saturating signed accumulator and holds the result.
module result_accum #(
  parameter int ACC_W = 16,
  parameter int BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [8:0]              in_data,
  input  logic                    in_signed,
  output logic                    in_ready,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [7:0]              out_count,
  output logic                    out_sat
);

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0]       BURST_C = 8'(BURST);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [7:0]              count_q;
  logic                    sat_q;

  logic [ACC_W-1:0]        ext_d;
  logic [ACC_W:0]          wide_d;
  logic signed [ACC_W-1:0] acc_d;
  logic                    sat_hit_d;
  logic [7:0]              count_d;
  logic                    accept_d;

  // Extend the sample, add with one guard bit, clamp when the guard disagrees with the sign.
  always_comb begin
    ext_d     = in_signed ? {{(ACC_W-9){in_data[8]}}, in_data} : {{(ACC_W-9){1'b0}}, in_data};
    wide_d    = {ext_d[ACC_W-1], ext_d} + {acc_q[ACC_W-1], acc_q};
    acc_d     = wide_d[ACC_W-1:0];
    sat_hit_d = 1'b0;
    if (wide_d[ACC_W] != wide_d[ACC_W-1]) begin
      acc_d     = wide_d[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_hit_d = 1'b1;
    end else begin
      acc_d     = wide_d[ACC_W-1:0];
      sat_hit_d = 1'b0;
    end
    count_d  = count_q + 8'd1;
    accept_d = in_valid && (state_q == ACCUM);
  end

  // Burst FSM and accumulator state; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= 8'd0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept_d) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            sat_q   <= sat_q | sat_hit_d;
            if (count_d == BURST_C || flush) begin
              state_q <= HOLD;
            end
          end else if (flush && count_q != 8'd0) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= 8'd0;
            sat_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Handshake flags decode straight from the state register; data shows running values.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

endmodule
